// File: rtl/l2_req_arbiter_if.sv
// L2 request/response channel between the miss arbiter (master) and the L2 cache (slave).
interface l2_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic              l2_req_valid;
  logic              l2_req_ack;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [3:0]        l2_req_opcode;
  logic [DATA_W-1:0] l2_req_store_data;
  logic              l2_rsp_valid;

  modport master (
    output l2_req_valid, l2_req_addr, l2_req_opcode, l2_req_store_data,
    input  l2_req_ack, l2_rsp_valid
  );

  modport slave (
    input  l2_req_valid, l2_req_addr, l2_req_opcode, l2_req_store_data,
    output l2_req_ack, l2_rsp_valid
  );
endinterface

// File: rtl/l2_req_arbiter.sv
// Shares the single L2 request port between the L1D and L1I miss paths, with
// round-robin on contention, a flush freeze, grant counters and a watchdog.
module l2_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 64,
  parameter int WDOG_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l1d_req_valid,
  input  logic [ADDR_W-1:0] l1d_req_addr,
  input  logic [3:0]        l1d_req_opcode,
  input  logic [DATA_W-1:0] l1d_req_store_data,
  input  logic              l1i_req_valid,
  input  logic [ADDR_W-1:0] l1i_req_addr,
  input  logic [3:0]        l1i_req_opcode,
  input  logic              flush_hold,
  l2_req_arbiter_if.master  l2,
  output logic              l1d_rsp_valid,
  output logic              l1i_rsp_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  l1d_grants,
  output logic [CNT_W-1:0]  l1i_grants,
  output logic              protocol_err,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  state_t state, state_nxt;

  logic              owner_i;
  logic              last_was_i;
  logic              pend_d, pend_i;
  logic [ADDR_W-1:0] hold_d_addr, hold_i_addr;
  logic [3:0]        hold_d_op, hold_i_op;
  logic [DATA_W-1:0] hold_d_data;
  logic [WDOG_W-1:0] wdog;

  logic active, acc_d, acc_i, eff_d, eff_i;
  logic grant, grant_i, rsp_fire;

  // A requester that is already pending or currently owns the port cannot
  // queue a second miss; that pulse is dropped.
  assign active = (state != IDLE);
  assign acc_d  = l1d_req_valid & ~pend_d & ~(active & ~owner_i);
  assign acc_i  = l1i_req_valid & ~pend_i & ~(active &  owner_i);
  assign eff_d  = pend_d | acc_d;
  assign eff_i  = pend_i | acc_i;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_i   = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush_hold && (eff_d || eff_i)) begin
          grant     = 1'b1;
          grant_i   = eff_i & (~eff_d | ~last_was_i);
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (l2.l2_rsp_valid) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end else if (l2.l2_req_ack) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (l2.l2_rsp_valid) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner_i      <= 1'b0;
      last_was_i   <= 1'b0;
      pend_d       <= 1'b0;
      pend_i       <= 1'b0;
      hold_d_addr  <= '0;
      hold_i_addr  <= '0;
      hold_d_op    <= '0;
      hold_i_op    <= '0;
      hold_d_data  <= '0;
      wdog         <= '0;
      l1d_grants   <= '0;
      l1i_grants   <= '0;
      protocol_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc_d) begin
        hold_d_addr <= l1d_req_addr;
        hold_d_op   <= l1d_req_opcode;
        hold_d_data <= l1d_req_store_data;
      end
      if (acc_i) begin
        hold_i_addr <= l1i_req_addr;
        hold_i_op   <= l1i_req_opcode;
      end
      pend_d <= eff_d & ~(grant & ~grant_i);
      pend_i <= eff_i & ~(grant &  grant_i);
      if ((l1d_req_valid & ~acc_d) | (l1i_req_valid & ~acc_i))
        protocol_err <= 1'b1;
      if (grant) begin
        owner_i    <= grant_i;
        last_was_i <= grant_i;
        wdog       <= '0;
        if (grant_i) l1i_grants <= l1i_grants + 1'b1;
        else         l1d_grants <= l1d_grants + 1'b1;
      end else if (active && wdog != WDOG_MAX) begin
        wdog <= wdog + 1'b1;
      end
      // The flag rises on the same edge the watchdog saturates.
      if (active && wdog == WDOG_MAX - 1'b1)
        timeout_err <= 1'b1;
    end
  end

  assign l2.l2_req_valid      = (state == REQ);
  assign l2.l2_req_addr       = owner_i ? hold_i_addr : hold_d_addr;
  assign l2.l2_req_opcode     = owner_i ? hold_i_op   : hold_d_op;
  assign l2.l2_req_store_data = hold_d_data;

  assign l1d_rsp_valid = rsp_fire & ~owner_i;
  assign l1i_rsp_valid = rsp_fire &  owner_i;
  assign busy          = active | pend_d | pend_i;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_l2_req_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 64;
  localparam int WDOG_W = 4;
  localparam int WD_MAX = (1 << WDOG_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              l1d_req_valid;
  logic [ADDR_W-1:0] l1d_req_addr;
  logic [3:0]        l1d_req_opcode;
  logic [DATA_W-1:0] l1d_req_store_data;
  logic              l1i_req_valid;
  logic [ADDR_W-1:0] l1i_req_addr;
  logic [3:0]        l1i_req_opcode;
  logic              flush_hold;
  logic              l1d_rsp_valid, l1i_rsp_valid, busy;
  logic [CNT_W-1:0]  l1d_grants, l1i_grants;
  logic              protocol_err, timeout_err;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  l2_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) l2_bus ();

  l2_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .WDOG_W(WDOG_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .l1d_req_valid      (l1d_req_valid),
    .l1d_req_addr       (l1d_req_addr),
    .l1d_req_opcode     (l1d_req_opcode),
    .l1d_req_store_data (l1d_req_store_data),
    .l1i_req_valid      (l1i_req_valid),
    .l1i_req_addr       (l1i_req_addr),
    .l1i_req_opcode     (l1i_req_opcode),
    .flush_hold         (flush_hold),
    .l2                 (l2_bus),
    .l1d_rsp_valid      (l1d_rsp_valid),
    .l1i_rsp_valid      (l1i_rsp_valid),
    .busy               (busy),
    .l1d_grants         (l1d_grants),
    .l1i_grants         (l1i_grants),
    .protocol_err       (protocol_err),
    .timeout_err        (timeout_err)
  );

  // Reference model: one in-flight transaction plus one captured request per L1
  // (index 0 = L1D, 1 = L1I).
  bit               m_active, m_acked, m_owner, m_prefer_i, m_perr, m_terr;
  bit               m_pend [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [3:0]        m_op   [2];
  logic [DATA_W-1:0] m_data;
  longint unsigned   m_grants [2];
  int                m_wd;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    m_active = 0; m_acked = 0; m_owner = 0; m_prefer_i = 1;
    m_perr = 0; m_terr = 0; m_wd = 0; m_data = '0;
    for (int r = 0; r < 2; r++) begin
      m_pend[r] = 0; m_addr[r] = '0; m_op[r] = '0; m_grants[r] = 0;
    end
  endtask

  task automatic modelStep();
    bit pulse [2];
    bit acc [2];
    bit eff [2];
    bit pick;
    pulse[0] = l1d_req_valid;
    pulse[1] = l1i_req_valid;
    for (int r = 0; r < 2; r++) begin
      acc[r] = pulse[r] && !m_pend[r] && !(m_active && m_owner == r[0]);
      if (pulse[r] && !acc[r]) m_perr = 1;
    end
    if (acc[0]) begin m_addr[0] = l1d_req_addr; m_op[0] = l1d_req_opcode; m_data = l1d_req_store_data; end
    if (acc[1]) begin m_addr[1] = l1i_req_addr; m_op[1] = l1i_req_opcode; end
    for (int r = 0; r < 2; r++) eff[r] = m_pend[r] || acc[r];
    if (m_active) begin
      if (m_wd < WD_MAX) m_wd++;
      if (m_wd == WD_MAX) m_terr = 1;
      if (l2_bus.l2_rsp_valid) m_active = 0;
      else if (l2_bus.l2_req_ack) m_acked = 1;
      for (int r = 0; r < 2; r++) m_pend[r] = eff[r];
    end else if (!flush_hold && (eff[0] || eff[1])) begin
      pick = eff[1] && (!eff[0] || m_prefer_i);
      m_active = 1; m_acked = 0; m_owner = pick; m_wd = 0;
      m_grants[pick] = m_grants[pick] + 1;
      m_prefer_i = !pick;
      m_pend[pick] = 0;
      m_pend[!pick] = eff[!pick];
    end else begin
      for (int r = 0; r < 2; r++) m_pend[r] = eff[r];
    end
  endtask

  task automatic tick();
    bit exp_valid;
    @(negedge clk);
    if (reset) begin
      modelReset();
    end else begin
      exp_valid = m_active && !m_acked;
      checkOutput("req_valid", 128'(l2_bus.l2_req_valid), 128'(exp_valid));
      if (exp_valid) begin
        checkOutput("req_addr", 128'(l2_bus.l2_req_addr), 128'(m_addr[m_owner]));
        checkOutput("req_opcode", 128'(l2_bus.l2_req_opcode), 128'(m_op[m_owner]));
        checkOutput("req_store_data", 128'(l2_bus.l2_req_store_data), 128'(m_data));
      end
      checkOutput("l1d_rsp", 128'(l1d_rsp_valid), 128'(m_active && l2_bus.l2_rsp_valid && !m_owner));
      checkOutput("l1i_rsp", 128'(l1i_rsp_valid), 128'(m_active && l2_bus.l2_rsp_valid && m_owner));
      checkOutput("busy", 128'(busy), 128'(m_active || m_pend[0] || m_pend[1]));
      checkOutput("l1d_grants", 128'(l1d_grants), 128'(m_grants[0]));
      checkOutput("l1i_grants", 128'(l1i_grants), 128'(m_grants[1]));
      checkOutput("protocol_err", 128'(protocol_err), 128'(m_perr));
      checkOutput("timeout_err", 128'(timeout_err), 128'(m_terr));
      modelStep();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic [ADDR_W-1:0] da, input logic [3:0] dop,
                               input logic [DATA_W-1:0] dd, input logic iv, input logic [ADDR_W-1:0] ia,
                               input logic [3:0] iop, input logic ack, input logic rsp);
    l1d_req_valid = dv; l1d_req_addr = da; l1d_req_opcode = dop; l1d_req_store_data = dd;
    l1i_req_valid = iv; l1i_req_addr = ia; l1i_req_opcode = iop;
    l2_bus.l2_req_ack = ack; l2_bus.l2_rsp_valid = rsp;
    tick();
    l1d_req_valid = 0; l1i_req_valid = 0;
    l2_bus.l2_req_ack = 0; l2_bus.l2_rsp_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, '0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  task automatic doReset();
    reset = 1;
    idle(2);
    reset = 0;
  endtask

  logic [DATA_W-1:0] rdata;

  initial begin
    reset = 1; flush_hold = 0;
    l1d_req_valid = 0; l1d_req_addr = '0; l1d_req_opcode = '0; l1d_req_store_data = '0;
    l1i_req_valid = 0; l1i_req_addr = '0; l1i_req_opcode = '0;
    l2_bus.l2_req_ack = 0; l2_bus.l2_rsp_valid = 0;
    modelReset();
    doReset();
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_valid", 128'(l2_bus.l2_req_valid), 128'(0));
    checkOutput("reset_grants", 128'(l1d_grants), 128'(0));

    // Single L1D miss: ack at t+1, response at t+4.
    applyStimulus(1, 32'h0000_0100, 4'h2, 128'hDEAD_BEEF, 0, '0, '0, 0, 0);
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 0);
    idle(2);
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 0, 1);
    idle(1);
    checkOutput("single_d_grants", 128'(l1d_grants), 128'(1));

    // Contention after reset: L1I first, then alternation.
    doReset();
    applyStimulus(1, 32'h0000_0D00, 4'h3, 128'h1111, 1, 32'h0000_0E00, 4'h5, 0, 0);
    checkOutput("contend_first_i", 128'(l1i_grants), 128'(1));
    checkOutput("contend_addr_i", 128'(l2_bus.l2_req_addr), 128'(32'h0000_0E00));
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 1);
    checkOutput("contend_d_waits", 128'(l1d_grants), 128'(0));
    idle(1);
    checkOutput("contend_d_next", 128'(l1d_grants), 128'(1));
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 32'h0000_2000 + 32'(k), 4'h1, 128'(k), 1, 32'h0000_3000 + 32'(k), 4'h4, 0, 0);
      applyStimulus(0, '0, '0, '0, 0, '0, '0, 0, 1);
      idle(1);
      applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 1);
      idle(1);
    end

    // flush_hold freezes the grant but keeps the captured request.
    doReset();
    flush_hold = 1;
    applyStimulus(0, '0, '0, '0, 1, 32'h0000_1000, 4'h6, 0, 0);
    idle(20);
    checkOutput("flush_no_req", 128'(l2_bus.l2_req_valid), 128'(0));
    flush_hold = 0;
    idle(1);
    checkOutput("flush_release_valid", 128'(l2_bus.l2_req_valid), 128'(1));
    checkOutput("flush_release_addr", 128'(l2_bus.l2_req_addr), 128'(32'h0000_1000));
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 1);
    idle(2);

    // Duplicate L1D pulse while it owns the port.
    doReset();
    applyStimulus(1, 32'h0000_2000, 4'h1, 128'hA, 0, '0, '0, 0, 0);
    applyStimulus(1, 32'h0000_3000, 4'h1, 128'hB, 0, '0, '0, 0, 0);
    checkOutput("dup_addr", 128'(l2_bus.l2_req_addr), 128'(32'h0000_2000));
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 0);
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 0, 1);
    idle(3);
    checkOutput("dup_perr", 128'(protocol_err), 128'(1));
    checkOutput("dup_one_grant", 128'(l1d_grants), 128'(1));

    // Reset while waiting for the response; the late response is ignored.
    doReset();
    applyStimulus(1, 32'h0000_4000, 4'h2, 128'hC, 0, '0, '0, 0, 0);
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 0);
    idle(1);
    reset = 1;
    idle(1);
    reset = 0;
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 0, 1);
    checkOutput("rst_mid_busy", 128'(busy), 128'(0));
    checkOutput("rst_mid_grants", 128'(l1d_grants), 128'(0));

    // Watchdog expiry with no response.
    doReset();
    applyStimulus(0, '0, '0, '0, 1, 32'h0000_5000, 4'h7, 0, 0);
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 1, 0);
    idle(18);
    checkOutput("wdog_timeout", 128'(timeout_err), 128'(1));
    applyStimulus(0, '0, '0, '0, 0, '0, '0, 0, 1);
    idle(2);

    // Random traffic.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      flush_hold = ($urandom_range(0, 9) == 0);
      rdata = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus($urandom_range(0, 4) == 0, $urandom, 4'($urandom), rdata,
                    $urandom_range(0, 4) == 0, $urandom, 4'($urandom),
                    $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0);
    end
    flush_hold = 0;
    idle(4);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
